dm_ctrl: RTL
============

// Module: dm_ctrl
// PURPOSE
//  Data-memory responder for the single-cycle core: consumes the ex stage store interface
//  (dm_wr_req/addr/data) and serves the lw read path (dm_rd_data).
//  Posts stores into a small FIFO store buffer that drains into a single-port word RAM.
//  Reads bypass from the buffer so a lw always sees the newest store.
//  Clears the RAM after reset via an INIT sequence.
// PARAMETERS
//  MEM_WORDS  1024  RAM depth in 32-bit words; power of 2; AW = log2(MEM_WORDS)
//  SB_DEPTH   4     store-buffer entries; power of 2, >= 2
// PORTS
//  clk             in   1   core clock; all state changes on rising edge
//  rst_n           in   1   asynchronous active-low reset
//  dm_wr_req_i     in   1   store request (sw in ex)
//  dm_wr_addr_i    in   32  store byte address
//  dm_wr_data_i    in   32  store data
//  dm_rd_en_i      in   1   load in progress (lw in ex); claims the RAM port
//  dm_rd_addr_i    in   32  load byte address
//  dm_rd_data_o    out  32  load data, combinational
//  dm_wr_stall_o   out  1   store buffer cannot accept; ex must hold the store
//  dm_init_busy_o  out  1   RAM clear in progress
//  sb_count_o      out  log2(SB_DEPTH)+1  store-buffer occupancy
// BEHAVIOUR
//  Addressing
//   - Word index = addr[AW+1:2]; addr[1:0] ignored; bits above AW+1 ignored, so addresses alias modulo MEM_WORDS*4.
//  Reset (async, rst_n=0)
//   - wr/rd ptrs=0, sb_count_o=0, state=INIT, init_idx=0, dm_init_busy_o=1.
//   - dm_wr_stall_o=1, dm_rd_data_o=0.
//   - Buffer contents discarded; reset mid-operation loses pending stores and restarts INIT.
//  FSM
//   - INIT: write 0 to RAM[init_idx] each cycle, init_idx++.
//     Leave INIT after the clear of word MEM_WORDS-1 (exactly MEM_WORDS cycles).
//     dm_init_busy_o=1 and dm_wr_stall_o=1 throughout; dm_rd_data_o=0; requests ignored.
//   - RUN: normal operation; no exit except reset.
//  Store accept (RUN)
//   - Push {word idx, data} when dm_wr_req_i=1 and sb_count_o<SB_DEPTH.
//   - dm_wr_stall_o = (state==INIT) | (sb_count_o==SB_DEPTH), from registered count only.
//     Stall does not drop when a drain occurs in the same cycle.
//   - Request while stalled is not stored; ex keeps it asserted.
//  Drain (RAM port arbitration)
//   - Pop oldest entry into RAM when count>0 and (dm_rd_en_i==0 or count==SB_DEPTH).
//   - Full buffer wins over a load (anti-starvation); at most one drain per cycle.
//   - Simultaneous push and pop: count unchanged; pointers wrap modulo SB_DEPTH.
//  Read path (RUN, combinational)
//   - dm_rd_data_o = data of the youngest valid buffer entry whose word idx matches.
//     If none matches, RAM[idx].
//   - An entry draining this cycle stays visible until the edge, so data is correct every cycle.
//   - A store pushed this cycle is not forwarded until the next cycle.
//  Latency
//   - Store visible to reads 1 cycle after acceptance.
//   - Reaches RAM after all older entries have drained.
// TESTING
//  1 Release reset -> dm_init_busy_o high for exactly 1024 cycles.
//    Stall high during INIT; read of 0x0 and 0xFFC = 0 after INIT.
//  2 RUN, rd_en=0: store 0x10<-0xDEADBEEF -> count 1 next cycle, 0 the cycle after.
//    Read 0x10 = 0xDEADBEEF from cycle+1 onward.
//  3 rd_en held 1: stores to 0x0/0x4/0x8/0xC -> count=4, stall=1.
//    5th store 0x10 not accepted; next edge forced drain -> count=3, stall=0.
//  4 rd_en=1: store 0x20<-1 then 0x20<-2 -> read 0x20 = 2 (youngest).
//    After full drain, read 0x20 = 2 from RAM.
//  5 Store 0x1003<-0xA5A5A5A5 (MEM_WORDS=1024) -> read 0x0 = 0xA5A5A5A5 (alias, low bits ignored).
//  6 3 entries pending, pulse rst_n low mid-cycle -> count=0 immediately, INIT restarts.
//    All reads 0 after INIT.

Source files
------------

// File: rtl/dm_ctrl.sv
// Data-memory responder: posts stores into a small FIFO store buffer that drains into a
// single-port word RAM, forwards buffered data to loads, and clears the RAM after reset.
module dm_ctrl #(
    parameter int MEM_WORDS = 1024,
    parameter int SB_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        dm_wr_req_i,
    input  logic [31:0]                 dm_wr_addr_i,
    input  logic [31:0]                 dm_wr_data_i,
    input  logic                        dm_rd_en_i,
    input  logic [31:0]                 dm_rd_addr_i,
    output logic [31:0]                 dm_rd_data_o,
    output logic                        dm_wr_stall_o,
    output logic                        dm_init_busy_o,
    output logic [$clog2(SB_DEPTH):0]   sb_count_o
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] SB_FULL = CW'(SB_DEPTH);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] init_idx_q, init_idx_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [AW-1:0] sb_idx_q  [SB_DEPTH];
    logic [31:0]   sb_data_q [SB_DEPTH];
    logic [31:0]   mem_q     [MEM_WORDS];

    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          push;
    logic          pop;
    logic          fwd_hit;
    logic [31:0]   fwd_data;
    logic [PW-1:0] slot;
    logic          unused_addr_bits;

    // Byte offset and bits above the RAM range are dropped, so addresses alias.
    assign wr_idx = dm_wr_addr_i[AW+1:2];
    assign rd_idx = dm_rd_addr_i[AW+1:2];
    assign unused_addr_bits = ^{dm_wr_addr_i[31:AW+2], dm_wr_addr_i[1:0],
                                dm_rd_addr_i[31:AW+2], dm_rd_addr_i[1:0]};

    // A full buffer takes the RAM port even from a load so stores can never starve.
    assign push = (state_q == ST_RUN) && dm_wr_req_i && (count_q != SB_FULL);
    assign pop  = (state_q == ST_RUN) && (count_q != '0) &&
                  (!dm_rd_en_i || (count_q == SB_FULL));

    assign dm_wr_stall_o  = (state_q == ST_INIT) || (count_q == SB_FULL);
    assign dm_init_busy_o = (state_q == ST_INIT);
    assign sb_count_o     = count_q;

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (state_q == ST_INIT) begin
            init_idx_d = init_idx_q + AW'(1);
            if (init_idx_q == AW'(MEM_WORDS - 1)) begin
                state_d = ST_RUN;
            end
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            sb_idx_q[wr_ptr_q]  <= wr_idx;
            sb_data_q[wr_ptr_q] <= dm_wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem_q[init_idx_q] <= '0;
        end else if (pop) begin
            mem_q[sb_idx_q[rd_ptr_q]] <= sb_data_q[rd_ptr_q];
        end
    end

    // Walk entries oldest to youngest so the last match is the newest store.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        slot     = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            slot = rd_ptr_q + PW'(k);
            if ((CW'(k) < count_q) && (sb_idx_q[slot] == rd_idx)) begin
                fwd_hit  = 1'b1;
                fwd_data = sb_data_q[slot];
            end
        end
        if (state_q == ST_INIT) begin
            dm_rd_data_o = '0;
        end else if (fwd_hit) begin
            dm_rd_data_o = fwd_data;
        end else begin
            dm_rd_data_o = mem_q[rd_idx];
        end
    end

endmodule
